// File: rtl/spi_flash_responder_pkg.sv
// Opcodes and FSM encoding shared by the SPI flash responder and the SPI flash master.
package spi_flash_responder_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmd    = 3'd1,
    StId     = 3'd2,
    StStat   = 3'd3,
    StAddr   = 3'd4,
    StData   = 3'd5,
    StIgnore = 3'd6
  } state_e;

  function automatic state_e cmd_to_state(input logic [7:0] opcode);
    case (opcode)
      CMD_RDID: return StId;
      CMD_RDSR: return StStat;
      CMD_READ: return StAddr;
      default:  return StIgnore;
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus edge detection on the synchronised sck/ss.
module spi_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic ss,
  input  logic sck,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  // ss resets high so a deselected bus does not look like a fresh select.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_prev_q   <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ss_meta_q   <= ss;
      ss_sync_q   <= ss_meta_q;
      ss_prev_q   <= ss_sync_q;
      sck_meta_q  <= sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign ss_fall  = ~ss_sync_q & ss_prev_q;
  assign ss_rise  = ss_sync_q & ~ss_prev_q;
  assign mosi_s   = mosi_sync_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave that answers RDID, RDSR and READ like a serial flash, oversampled in clk.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd,
  output logic              busy
);

  logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;

  spi_pin_sync u_pin_sync (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_fall  (ss_fall),
    .ss_rise  (ss_rise),
    .mosi_s   (mosi_s)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [15:0]       addr_q, addr_d;
  logic [1:0]        addr_cnt_q, addr_cnt_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              cap_q, cap_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              miso_q, miso_d;

  logic [7:0]  rx_byte;
  logic [23:0] addr_full;
  logic        byte_done;

  assign rx_byte   = {rx_q, mosi_s};
  assign addr_full = {addr_q, rx_byte};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      2'd2:    return JEDEC_ID[7:0];
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      addr_cnt_q  <= '0;
      id_idx_q    <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      cap_q       <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      addr_cnt_q  <= addr_cnt_d;
      id_idx_q    <= id_idx_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      cap_q       <= cap_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      miso_q      <= miso_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    addr_cnt_d  = addr_cnt_q;
    id_idx_d    = id_idx_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = 1'b0;
    cap_d       = rd_en_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    miso_d      = miso_q;

    if (state_q == StIdle) begin
      miso_d = 1'b0;
      if (ss_fall) begin
        state_d    = StCmd;
        bit_cnt_d  = '0;
        rx_d       = '0;
        tx_d       = '0;
        addr_cnt_d = '0;
        id_idx_d   = '0;
      end
    end else if (ss_rise) begin
      // Deselect wins over any coincident sck edge; a partial byte is dropped.
      state_d   = StIdle;
      bit_cnt_d = '0;
      tx_d      = '0;
      miso_d    = 1'b0;
      cap_d     = 1'b0;
    end else begin
      if (sck_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (cap_q) begin
        tx_d = rd_data;
      end
      if (sck_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      // Response bytes are loaded on the last rise so the following fall drives their MSB.
      if (byte_done) begin
        case (state_q)
          StCmd: begin
            cmd_d       = rx_byte;
            cmd_valid_d = 1'b1;
            state_d     = cmd_to_state(rx_byte);
            addr_cnt_d  = '0;
            if (rx_byte == CMD_RDID) begin
              tx_d     = id_byte(2'd0);
              id_idx_d = 2'd1;
            end else if (rx_byte == CMD_RDSR) begin
              tx_d = STATUS;
            end else begin
              tx_d = 8'h00;
            end
          end
          StId: begin
            tx_d = id_byte(id_idx_q);
            if (id_idx_q != 2'd3) begin
              id_idx_d = id_idx_q + 2'd1;
            end
          end
          StStat: tx_d = STATUS;
          StAddr: begin
            addr_d = addr_full[15:0];
            if (addr_cnt_q == 2'd2) begin
              rd_addr_d = addr_full[ADDR_W-1:0];
              rd_en_d   = 1'b1;
              state_d   = StData;
            end else begin
              addr_cnt_d = addr_cnt_q + 2'd1;
            end
          end
          StData: begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            rd_en_d   = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = (state_q != StIdle);
  assign busy      = (state_q != StIdle);
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;

endmodule
